// File: rtl/ca_run_ctrl.sv
// rtl/ca_run_ctrl.sv - run sequencer for a 1D cellular-automaton array
//
// Latches a run configuration on start, loads the seed into the external
// array, then alternates EMIT (stream one generation) and STEP (advance the
// array by one generation) until the last generation has been accepted.
// Whenever the array is not being loaded or stepped it is frozen by feeding
// its own output back through the set_state path.
//
// Optional build macro: CA_RUN_FIXPOINT_EN
//   When defined, the run also ends early once a generation equals the one
//   before it (the automaton has reached a fixed point).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             run request, sampled only while idle
//   rule_in, seed, gens, wrap, left_fix, right_fix
//                     run configuration, latched on an accepted start
//   busy, done        run in progress / one-cycle end-of-run pulse
//   ca_rule, ca_left, ca_right, ca_state, ca_set_state
//                     control of the external CA array
//   ca_out            current array state
//   gen_data, gen_index, gen_last, gen_valid, gen_ready
//                     generation stream (valid/ready handshake)
module ca_run_ctrl #(
    parameter int WIDTH = 32,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       rule_in,
    input  logic [WIDTH-1:0] seed,
    input  logic [GEN_W-1:0] gens,
    input  logic             wrap,
    input  logic             left_fix,
    input  logic             right_fix,
    output logic             busy,
    output logic             done,
    output logic [7:0]       ca_rule,
    output logic             ca_left,
    output logic             ca_right,
    output logic [WIDTH-1:0] ca_state,
    output logic             ca_set_state,
    input  logic [WIDTH-1:0] ca_out,
    output logic [WIDTH-1:0] gen_data,
    output logic [GEN_W-1:0] gen_index,
    output logic             gen_last,
    output logic             gen_valid,
    input  logic             gen_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [7:0]       rule_q;
    logic [WIDTH-1:0] seed_q;
    logic [GEN_W-1:0] gens_q;
    logic             wrap_q;
    logic             left_fix_q;
    logic             right_fix_q;
    logic [GEN_W-1:0] cnt;
    logic             last_cond;

`ifdef CA_RUN_FIXPOINT_EN
    // Array state captured just before each step; compared against the
    // freshly stepped state to detect a fixed point.
    logic [WIDTH-1:0] prev_q;
    logic             fix_hit;

    assign fix_hit = (cnt != '0) && (ca_out == prev_q);
`endif

    // Compare happens on the current cnt before STEP increments it, so the
    // all-ones gens value terminates without the counter ever wrapping.
`ifdef CA_RUN_FIXPOINT_EN
    assign last_cond = (cnt == gens_q) || fix_hit;
`else
    assign last_cond = (cnt == gens_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rule_q      <= '0;
            seed_q      <= '0;
            gens_q      <= '0;
            wrap_q      <= 1'b0;
            left_fix_q  <= 1'b0;
            right_fix_q <= 1'b0;
            cnt         <= '0;
`ifdef CA_RUN_FIXPOINT_EN
            prev_q      <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rule_q      <= rule_in;
                        seed_q      <= seed;
                        gens_q      <= gens;
                        wrap_q      <= wrap;
                        left_fix_q  <= left_fix;
                        right_fix_q <= right_fix;
                    end
                end
                S_LOAD: cnt <= '0;
                S_STEP: begin
                    cnt <= cnt + 1'b1;
`ifdef CA_RUN_FIXPOINT_EN
                    prev_q <= ca_out;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = 1'b1;
        done         = 1'b0;
        ca_set_state = 1'b1;
        ca_state     = ca_out;
        gen_valid    = 1'b0;
        gen_last     = 1'b0;
        gen_index    = '0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                ca_state = seed_q;
                state_nx = S_EMIT;
            end
            S_EMIT: begin
                gen_valid = 1'b1;
                gen_index = cnt;
                gen_last  = last_cond;
                if (gen_ready) state_nx = last_cond ? S_DONE : S_STEP;
            end
            S_STEP: begin
                ca_set_state = 1'b0;
                state_nx     = S_EMIT;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign ca_rule  = rule_q;
    assign ca_left  = wrap_q ? ca_out[WIDTH-1] : left_fix_q;
    assign ca_right = wrap_q ? ca_out[0]       : right_fix_q;
    assign gen_data = ca_out;

endmodule

// File: tb/tb_ca_run_ctrl.sv
// tb/tb_ca_run_ctrl.sv - directed self-checking bench for ca_run_ctrl
module tb_ca_run_ctrl;

    localparam int WIDTH = 32;
    localparam int GEN_W = 16;
    localparam int MAXG  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       rule_in;
    logic [WIDTH-1:0] seed;
    logic [GEN_W-1:0] gens;
    logic             wrap;
    logic             left_fix;
    logic             right_fix;
    logic             busy;
    logic             done;
    logic [7:0]       ca_rule;
    logic             ca_left;
    logic             ca_right;
    logic [WIDTH-1:0] ca_state;
    logic             ca_set_state;
    logic [WIDTH-1:0] ca_out;
    logic [WIDTH-1:0] gen_data;
    logic [GEN_W-1:0] gen_index;
    logic             gen_last;
    logic             gen_valid;
    logic             gen_ready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ca_run_ctrl #(.WIDTH(WIDTH), .GEN_W(GEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rule_in(rule_in), .seed(seed),
        .gens(gens), .wrap(wrap), .left_fix(left_fix), .right_fix(right_fix),
        .busy(busy), .done(done), .ca_rule(ca_rule), .ca_left(ca_left),
        .ca_right(ca_right), .ca_state(ca_state), .ca_set_state(ca_set_state),
        .ca_out(ca_out), .gen_data(gen_data), .gen_index(gen_index),
        .gen_last(gen_last), .gen_valid(gen_valid), .gen_ready(gen_ready)
    );

    // Behavioural CA array: loads on set_state, else steps with the rule.
    logic [WIDTH-1:0] arr = '0;
    logic [WIDTH-1:0] arr_nx;

    always_comb begin
        arr_nx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic l, c, r;
            c = arr[i];
            l = (i == 0)         ? ca_left  : arr[(i + WIDTH - 1) % WIDTH];
            r = (i == WIDTH - 1) ? ca_right : arr[(i + 1) % WIDTH];
            arr_nx[i] = ca_rule[{l, c, r}];
        end
    end

    always @(posedge clk) arr <= ca_set_state ? ca_state : arr_nx;
    assign ca_out = arr;

    // Run capture
    logic [WIDTH-1:0] g_data [MAXG];
    logic [GEN_W-1:0] g_idx  [MAXG];
    logic             g_last [MAXG];
    int               g_iter [MAXG];
    int               n_gen;
    int               n_done;
    int               stall_bad;
    int               stall_seen;
    bit               timed_out;
    bit               busy_after_start;

    task automatic run_collect(input logic [7:0] r, input logic [WIDTH-1:0] s,
                               input logic [GEN_W-1:0] g, input logic w,
                               input logic lf, input logic rf, input int stall_n);
        logic [WIDTH-1:0] snap_data, snap_out;
        int  stall_cnt;
        bit  done_seen, finished;
        n_gen = 0; n_done = 0; stall_bad = 0; stall_seen = 0;
        stall_cnt = 0; done_seen = 0; finished = 0;
        snap_data = '0; snap_out = '0;
        @(negedge clk);
        rule_in = r; seed = s; gens = g; wrap = w; left_fix = lf; right_fix = rf;
        start = 1'b1; gen_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_after_start = busy;
        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            if (done) begin n_done++; done_seen = 1; end
            if (done_seen && !busy && !done) begin finished = 1; break; end
            if (gen_valid && stall_n > 0 && gen_index == 1 && stall_cnt < stall_n) begin
                if (stall_cnt == 0) begin
                    snap_data = gen_data; snap_out = ca_out;
                end else if (gen_data !== snap_data || ca_out !== snap_out) begin
                    stall_bad++;
                end
                if (ca_set_state !== 1'b1) stall_bad++;
                stall_cnt++; stall_seen++;
                gen_ready = 1'b0;
                // Config changes and start while busy must be ignored.
                start = 1'b1; rule_in = 8'hFF; seed = $urandom; gens = 0; wrap = 1'b1;
            end else begin
                gen_ready = 1'b1;
                start = 1'b0; rule_in = r; seed = s; gens = g; wrap = w;
                if (gen_valid && n_gen < MAXG) begin
                    if (stall_cnt > 0 && stall_cnt == stall_n && n_gen == 1 &&
                        (gen_data !== snap_data || ca_out !== snap_out)) stall_bad++;
                    g_data[n_gen] = gen_data;
                    g_idx[n_gen]  = gen_index;
                    g_last[n_gen] = gen_last;
                    g_iter[n_gen] = it;
                    n_gen++;
                end
            end
        end
        start = 1'b0; gen_ready = 1'b1;
        timed_out = !finished;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (gen_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", gen_valid); end
        checks++; if (gen_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", gen_last); end
        checks++; if (gen_index !== 16'd0) begin failures++; $display("FAIL reset_index got=%0d exp=0", gen_index); end
        checks++; if (ca_set_state !== 1'b1) begin failures++; $display("FAIL reset_hold got=%b exp=1", ca_set_state); end
        checks++; if (ca_rule !== 8'd0) begin failures++; $display("FAIL reset_rule got=%h exp=00", ca_rule); end
        checks++; if ({ca_left, ca_right} !== 2'b00) begin failures++; $display("FAIL reset_bound got=%b exp=00", {ca_left, ca_right}); end
        checks++; if (gen_data !== arr) begin failures++; $display("FAIL reset_gen_data got=%h exp=%h", gen_data, arr); end
    endtask

    task automatic check_rule90_seq(input string tag);
        logic [WIDTH-1:0] exp_d [4];
        exp_d[0] = 32'h0001_0000; exp_d[1] = 32'h0002_8000;
        exp_d[2] = 32'h0004_4000; exp_d[3] = 32'h000A_A000;
        checks++; if (timed_out) begin failures++; $display("FAIL %s_timeout got=1 exp=0", tag); end
        checks++; if (n_gen !== 4) begin failures++; $display("FAIL %s_count got=%0d exp=4", tag, n_gen); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL %s_done got=%0d exp=1", tag, n_done); end
        for (int i = 0; i < 4 && i < n_gen; i++) begin
            checks++; if (g_data[i] !== exp_d[i]) begin failures++; $display("FAIL %s_data%0d got=%h exp=%h", tag, i, g_data[i], exp_d[i]); end
            checks++; if (g_idx[i] !== i[GEN_W-1:0]) begin failures++; $display("FAIL %s_index%0d got=%0d exp=%0d", tag, i, g_idx[i], i); end
            checks++; if (g_last[i] !== (i == 3)) begin failures++; $display("FAIL %s_last%0d got=%b exp=%b", tag, i, g_last[i], i == 3); end
        end
    endtask

    task automatic test_rule90_basic();
        run_collect(8'd90, 32'h0001_0000, 16'd3, 1'b0, 1'b0, 1'b0, 0);
        check_rule90_seq("r90");
        checks++; if (busy_after_start !== 1'b1) begin failures++; $display("FAIL r90_busy got=%b exp=1", busy_after_start); end
        for (int i = 0; i < 4 && i < n_gen; i++) begin
            checks++; if (g_iter[i] !== 2 * i) begin failures++; $display("FAIL r90_timing%0d got=%0d exp=%0d", i, g_iter[i], 2 * i); end
        end
    endtask

    task automatic test_wrap();
        run_collect(8'd90, 32'h0000_0001, 16'd1, 1'b1, 1'b0, 1'b0, 0);
        checks++; if (n_gen !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", n_gen); end
        checks++; if (g_data[0] !== 32'h0000_0001) begin failures++; $display("FAIL wrap_d0 got=%h exp=00000001", g_data[0]); end
        checks++; if (g_data[1] !== 32'h8000_0002) begin failures++; $display("FAIL wrap_d1 got=%h exp=80000002", g_data[1]); end
        checks++; if (g_last[1] !== 1'b1) begin failures++; $display("FAIL wrap_last got=%b exp=1", g_last[1]); end
    endtask

    task automatic test_fixed_boundary();
        run_collect(8'd90, 32'h0000_0000, 16'd1, 1'b0, 1'b1, 1'b1, 0);
        checks++; if (n_gen !== 2) begin failures++; $display("FAIL fix_count got=%0d exp=2", n_gen); end
        checks++; if (g_data[0] !== 32'h0000_0000) begin failures++; $display("FAIL fix_d0 got=%h exp=00000000", g_data[0]); end
        checks++; if (g_data[1] !== 32'h8000_0001) begin failures++; $display("FAIL fix_d1 got=%h exp=80000001", g_data[1]); end
    endtask

    task automatic test_backpressure();
        run_collect(8'd90, 32'h0001_0000, 16'd3, 1'b0, 1'b0, 1'b0, 5);
        check_rule90_seq("bp");
        checks++; if (stall_seen !== 5) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=5", stall_seen); end
        checks++; if (stall_bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", stall_bad); end
    endtask

    task automatic test_fixpoint();
        int exp_n;
`ifdef CA_RUN_FIXPOINT_EN
        exp_n = 3;
`else
        exp_n = 11;
`endif
        run_collect(8'd0, 32'hFFFF_FFFF, 16'd10, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (timed_out) begin failures++; $display("FAIL fp_timeout got=1 exp=0"); end
        checks++; if (n_gen !== exp_n) begin failures++; $display("FAIL fp_count got=%0d exp=%0d", n_gen, exp_n); end
        checks++; if (g_data[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL fp_d0 got=%h exp=ffffffff", g_data[0]); end
        if (n_gen == exp_n) begin
            checks++; if (g_idx[exp_n-1] !== GEN_W'(exp_n - 1)) begin failures++; $display("FAIL fp_last_index got=%0d exp=%0d", g_idx[exp_n-1], exp_n - 1); end
            checks++; if (g_data[exp_n-1] !== 32'h0) begin failures++; $display("FAIL fp_last_data got=%h exp=0", g_data[exp_n-1]); end
            checks++; if (g_last[exp_n-1] !== 1'b1 || g_last[exp_n-2] !== 1'b0) begin failures++; $display("FAIL fp_last_flag got=%b%b exp=01", g_last[exp_n-2], g_last[exp_n-1]); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit found = 0;
        @(negedge clk);
        rule_in = 8'd90; seed = 32'h0001_0000; gens = 16'd3; wrap = 1'b0;
        left_fix = 1'b0; right_fix = 1'b0; start = 1'b1; gen_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            if (gen_valid && gen_index == 1) begin found = 1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL rstmid_reach got=0 exp=1"); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (gen_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", gen_valid); end
        checks++; if (ca_set_state !== 1'b1) begin failures++; $display("FAIL rstmid_hold got=%b exp=1", ca_set_state); end
        @(negedge clk);
        checks++; if (ca_out !== 32'h0002_8000) begin failures++; $display("FAIL rstmid_array got=%h exp=00028000", ca_out); end
        rst = 1'b0;
        run_collect(8'd90, 32'h1234_5678, 16'd0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (n_gen !== 1) begin failures++; $display("FAIL gens0_count got=%0d exp=1", n_gen); end
        checks++; if (g_data[0] !== 32'h1234_5678) begin failures++; $display("FAIL gens0_data got=%h exp=12345678", g_data[0]); end
        checks++; if (g_last[0] !== 1'b1 || g_idx[0] !== 16'd0) begin failures++; $display("FAIL gens0_last got=%b/%0d exp=1/0", g_last[0], g_idx[0]); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL gens0_done got=%0d exp=1", n_done); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rule_in = '0; seed = '0; gens = '0;
        wrap = 1'b0; left_fix = 1'b0; right_fix = 1'b0; gen_ready = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        rst = 1'b0;
        test_rule90_basic();
        test_wrap();
        test_fixed_boundary();
        test_backpressure();
        test_fixpoint();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
